// File: rtl/bullet_pool.sv
// Bullet slot pool: allocates slots on fire requests and sweeps/retires bullets once per frame.
// Optional BULLET_COUNT_EN adds the registered activeCount output.
module bullet_pool #(
  parameter int unsigned MAX_BULLETS  = 64,
  parameter int unsigned BULLET_SIZE  = 8,
  parameter int unsigned VIDEO_WIDTH  = 640,
  parameter int unsigned VIDEO_HEIGHT = 480,
  parameter int unsigned SPEED        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     screenEnd,
  input  logic                     clearAll,
  input  logic                     fire,
  input  logic [8:0]               fireX,
  input  logic [8:0]               fireY,
  input  logic [1:0]               fireDir,
  input  logic                     fireOwner,
  output logic [32*MAX_BULLETS-1:0] allBulletContents,
  output logic                     fireAccepted,
  output logic                     fireDropped
`ifdef BULLET_COUNT_EN
  ,
  output logic [6:0]               activeCount
`endif
);

  localparam int unsigned XLIM  = (VIDEO_WIDTH < 512) ? VIDEO_WIDTH : 512;
  localparam int unsigned XMAX  = XLIM - BULLET_SIZE;
  localparam int unsigned YMAX  = VIDEO_HEIGHT - BULLET_SIZE;
  localparam int unsigned IDX_W = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;

  typedef enum logic [0:0] {IDLE, UPDATE} state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           se_q;
  logic                           pend_v_q, pend_v_d;
  logic [8:0]                     pend_x_q, pend_x_d;
  logic [8:0]                     pend_y_q, pend_y_d;
  logic [1:0]                     pend_dir_q, pend_dir_d;
  logic                           pend_own_q, pend_own_d;
  logic [MAX_BULLETS-1:0][31:0]   slots_q, slots_d;
  logic                           acc_q, acc_d;
  logic                           drop_q, drop_d;

  logic                           se_rise;
  logic                           fire_ok;
  logic                           free_found;
  logic [IDX_W-1:0]               free_idx;
  logic [31:0]                    cur;
  logic [9:0]                     nx, ny;
  logic                           retire;
  logic [31:0]                    moved;

  assign se_rise = screenEnd & ~se_q;
  assign fire_ok = ({1'b0, fireX} <= 10'(XMAX)) && ({1'b0, fireY} <= 10'(YMAX));

  // Lowest-index inactive slot
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(MAX_BULLETS) - 1; i >= 0; i--) begin
      if (!slots_q[i][5]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Next position of the slot under the sweep index; out-of-field (incl. negative wrap) retires
  always_comb begin
    cur = slots_q[idx_q];
    nx  = {1'b0, cur[31:23]};
    ny  = {1'b0, cur[22:14]};
    case (cur[13:12])
      2'b00:   ny = {1'b0, cur[22:14]} - 10'(SPEED);
      2'b01:   nx = {1'b0, cur[31:23]} + 10'(SPEED);
      2'b10:   ny = {1'b0, cur[22:14]} + 10'(SPEED);
      default: nx = {1'b0, cur[31:23]} - 10'(SPEED);
    endcase
    retire = (nx > 10'(XMAX)) || (ny > 10'(YMAX));
    moved  = {nx[8:0], ny[8:0], cur[13:0]};
  end

  // FSM next state, allocation, sweep and fire sampling
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    slots_d    = slots_q;
    pend_v_d   = pend_v_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    pend_dir_d = pend_dir_q;
    pend_own_d = pend_own_q;
    acc_d      = 1'b0;
    drop_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (se_rise) begin
          state_d = UPDATE;
          idx_d   = '0;
        end else if (pend_v_q) begin
          pend_v_d = 1'b0;
          if (free_found) begin
            slots_d[free_idx] = {pend_x_q, pend_y_q, pend_dir_q, pend_own_q, 5'd0, 1'b1, 5'd0};
            acc_d             = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      UPDATE: begin
        if (cur[5]) begin
          slots_d[idx_q] = retire ? 32'd0 : moved;
        end
        if (idx_q == IDX_W'(MAX_BULLETS - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire) begin
      if (!fire_ok || pend_v_q) begin
        drop_d = 1'b1;
      end else begin
        pend_v_d   = 1'b1;
        pend_x_d   = fireX;
        pend_y_d   = fireY;
        pend_dir_d = fireDir;
        pend_own_d = fireOwner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clearAll) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      se_q       <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      pend_dir_q <= '0;
      pend_own_q <= 1'b0;
      slots_q    <= '0;
      acc_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      se_q       <= screenEnd;
      pend_v_q   <= pend_v_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pend_dir_q <= pend_dir_d;
      pend_own_q <= pend_own_d;
      slots_q    <= slots_d;
      acc_q      <= acc_d;
      drop_q     <= drop_d;
    end
  end

  assign allBulletContents = slots_q;
  assign fireAccepted      = acc_q;
  assign fireDropped       = drop_q;

`ifdef BULLET_COUNT_EN
  logic [6:0] cnt_q, cnt_d;

  // Allocation (IDLE) and retirement (UPDATE) never coincide
  always_comb begin
    cnt_d = cnt_q;
    if (acc_d) begin
      cnt_d = cnt_q + 7'd1;
    end else if ((state_q == UPDATE) && cur[5] && retire) begin
      cnt_d = cnt_q - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clearAll) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign activeCount = cnt_q;
`endif

endmodule

// File: tb/tb_bullet_pool.sv
// Directed self-checking bench for bullet_pool (default 64 slots, 640x480).
`timescale 1ns/1ps
module tb_bullet_pool;

  localparam int NB = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            screenEnd = 1'b0;
  logic            clearAll = 1'b0;
  logic            fire = 1'b0;
  logic [8:0]      fireX = '0;
  logic [8:0]      fireY = '0;
  logic [1:0]      fireDir = '0;
  logic            fireOwner = 1'b0;
  logic [32*NB-1:0] bus;
  logic            acc;
  logic            drop;
`ifdef BULLET_COUNT_EN
  logic [6:0]      cnt;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [32*NB-1:0] exp_bus;

  bullet_pool dut (
    .clk               (clk),
    .reset             (reset),
    .screenEnd         (screenEnd),
    .clearAll          (clearAll),
    .fire              (fire),
    .fireX             (fireX),
    .fireY             (fireY),
    .fireDir           (fireDir),
    .fireOwner         (fireOwner),
    .allBulletContents (bus),
    .fireAccepted      (acc),
    .fireDropped       (drop)
`ifdef BULLET_COUNT_EN
    ,
    .activeCount       (cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clearAll = 1'b1;
    tick();
    clearAll = 1'b0;
  endtask

  task automatic strobe();
    screenEnd = 1'b1;
    repeat (4) tick();
    screenEnd = 1'b0;
    repeat (70) tick();
  endtask

  task automatic shoot(input int x, input int y, input int d, input int o);
    fireX = 9'(x); fireY = 9'(y); fireDir = 2'(d); fireOwner = 1'(o);
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] mk(input int x, input int y, input int d, input int o);
    return {9'(x), 9'(y), 2'(d), 1'(o), 5'd0, 1'b1, 5'd0};
  endfunction

  function automatic logic [31:0] slot_of(input logic [32*NB-1:0] b, input int i);
    return b[i*32 +: 32];
  endfunction

  function automatic int first_diff(input logic [32*NB-1:0] a, input logic [32*NB-1:0] b);
    for (int i = 0; i < NB; i++) begin
      if (a[i*32 +: 32] !== b[i*32 +: 32]) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    int fd;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    fd = first_diff(bus, '0);
    vectors++; if (fd != -1) begin errors++; $display("FAIL reset_bus: slot %0d got %h want 0", fd, slot_of(bus, fd)); end
    vectors++; if (acc !== 1'b0) begin errors++; $display("FAIL reset_acc: got %b want 0", acc); end
    vectors++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop); end
`ifdef BULLET_COUNT_EN
    vectors++; if (cnt !== 7'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
`endif
  endtask

  task automatic test_fire();
    int fd;
    fireX = 9'd100; fireY = 9'd200; fireDir = 2'b01; fireOwner = 1'b1;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    vectors++; if (acc !== 1'b0 || slot_of(bus, 0) !== 32'd0) begin errors++; $display("FAIL fire_latch: acc %b slot0 %h want 0/0", acc, slot_of(bus, 0)); end
    tick();
    vectors++; if (acc !== 1'b1) begin errors++; $display("FAIL fire_acc: got %b want 1", acc); end
    exp_bus = '0;
    exp_bus[31:0] = mk(100, 200, 1, 1);
    fd = first_diff(bus, exp_bus);
    vectors++; if (fd != -1) begin errors++; $display("FAIL fire_bus: slot %0d got %h want %h", fd, slot_of(bus, fd), slot_of(exp_bus, fd)); end
    tick();
    vectors++; if (acc !== 1'b0) begin errors++; $display("FAIL fire_acc_pulse: got %b want 0", acc); end
  endtask

  task automatic test_move();
    int fd;
    for (int s = 1; s <= 3; s++) begin
      strobe();
      vectors++;
      if (slot_of(bus, 0) !== mk(100 + 4*s, 200, 1, 1)) begin
        errors++; $display("FAIL move_%0d: got %h want %h", s, slot_of(bus, 0), mk(100 + 4*s, 200, 1, 1));
      end
    end
    exp_bus = '0;
    exp_bus[31:0] = mk(112, 200, 1, 1);
    fd = first_diff(bus, exp_bus);
    vectors++; if (fd != -1) begin errors++; $display("FAIL move_bus: slot %0d got %h want %h", fd, slot_of(bus, fd), slot_of(exp_bus, fd)); end
  endtask

  task automatic test_retire();
    do_clear();
    shoot(502, 50, 1, 0);
    tick();
    vectors++; if (slot_of(bus, 0) !== mk(502, 50, 1, 0)) begin errors++; $display("FAIL retire_x_spawn: got %h want %h", slot_of(bus, 0), mk(502, 50, 1, 0)); end
`ifdef BULLET_COUNT_EN
    vectors++; if (cnt !== 7'd1) begin errors++; $display("FAIL retire_cnt_up: got %0d want 1", cnt); end
`endif
    strobe();
    vectors++; if (slot_of(bus, 0) !== 32'd0) begin errors++; $display("FAIL retire_x: got %h want 0", slot_of(bus, 0)); end
`ifdef BULLET_COUNT_EN
    vectors++; if (cnt !== 7'd0) begin errors++; $display("FAIL retire_cnt_x: got %0d want 0", cnt); end
`endif
    shoot(10, 3, 0, 1);
    strobe();
    vectors++; if (slot_of(bus, 0) !== 32'd0) begin errors++; $display("FAIL retire_y: got %h want 0", slot_of(bus, 0)); end
`ifdef BULLET_COUNT_EN
    vectors++; if (cnt !== 7'd0) begin errors++; $display("FAIL retire_cnt_y: got %0d want 0", cnt); end
`endif
    shoot(500, 472, 1, 0);
    strobe();
    vectors++; if (slot_of(bus, 0) !== mk(504, 472, 1, 0)) begin errors++; $display("FAIL edge_keep: got %h want %h", slot_of(bus, 0), mk(504, 472, 1, 0)); end
  endtask

  task automatic test_full();
    int fd;
    do_clear();
    exp_bus = '0;
    for (int i = 0; i < NB; i++) begin
      shoot(i*4, i, i % 4, i % 2);
      exp_bus[i*32 +: 32] = mk(i*4, i, i % 4, i % 2);
    end
    fd = first_diff(bus, exp_bus);
    vectors++; if (fd != -1) begin errors++; $display("FAIL full_bus: slot %0d got %h want %h", fd, slot_of(bus, fd), slot_of(exp_bus, fd)); end
`ifdef BULLET_COUNT_EN
    vectors++; if (cnt !== 7'd64) begin errors++; $display("FAIL full_cnt: got %0d want 64", cnt); end
`endif
    fireX = 9'd7; fireY = 9'd7; fireDir = 2'b00; fireOwner = 1'b0;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    vectors++; if (drop !== 1'b0) begin errors++; $display("FAIL full_latch_drop: got %b want 0", drop); end
    tick();
    vectors++; if (drop !== 1'b1 || acc !== 1'b0) begin errors++; $display("FAIL full_drop: drop %b acc %b want 1/0", drop, acc); end
    fd = first_diff(bus, exp_bus);
    vectors++; if (fd != -1) begin errors++; $display("FAIL full_unchanged: slot %0d got %h want %h", fd, slot_of(bus, fd), slot_of(exp_bus, fd)); end
    tick();
    vectors++; if (drop !== 1'b0) begin errors++; $display("FAIL full_drop_pulse: got %b want 0", drop); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    fireX = 9'd20; fireY = 9'd30; fireDir = 2'b10; fireOwner = 1'b0;
    fire = 1'b1;
    tick();
    fireX = 9'd40; fireY = 9'd50;
    tick();
    fire = 1'b0;
    vectors++; if (acc !== 1'b1 || drop !== 1'b1) begin errors++; $display("FAIL b2b_pulses: acc %b drop %b want 1/1", acc, drop); end
    vectors++; if (slot_of(bus, 0) !== mk(20, 30, 2, 0)) begin errors++; $display("FAIL b2b_slot0: got %h want %h", slot_of(bus, 0), mk(20, 30, 2, 0)); end
    tick();
    vectors++; if (acc !== 1'b0 || slot_of(bus, 1) !== 32'd0) begin errors++; $display("FAIL b2b_second: acc %b slot1 %h want 0/0", acc, slot_of(bus, 1)); end
  endtask

  task automatic test_simultaneous();
    int n;
    do_clear();
    fireX = 9'd60; fireY = 9'd70; fireDir = 2'b11; fireOwner = 1'b1;
    fire = 1'b1;
    screenEnd = 1'b1;
    tick();
    fire = 1'b0;
    n = 0;
    while (acc !== 1'b1 && n < 200) begin
      if (n == 3) screenEnd = 1'b0;
      tick();
      n++;
    end
    screenEnd = 1'b0;
    vectors++; if (n != 65) begin errors++; $display("FAIL simul_latency: got %0d cycles want 65", n); end
    vectors++; if (slot_of(bus, 0) !== mk(60, 70, 3, 1)) begin errors++; $display("FAIL simul_unmoved: got %h want %h", slot_of(bus, 0), mk(60, 70, 3, 1)); end
    tick();
    fireX = 9'd505; fireY = 9'd10;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    vectors++; if (drop !== 1'b1) begin errors++; $display("FAIL range_x_drop: got %b want 1", drop); end
    tick();
    vectors++; if (acc !== 1'b0 || slot_of(bus, 1) !== 32'd0) begin errors++; $display("FAIL range_x_slot: acc %b slot1 %h want 0/0", acc, slot_of(bus, 1)); end
    fireX = 9'd10; fireY = 9'd473;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    vectors++; if (drop !== 1'b1) begin errors++; $display("FAIL range_y_drop: got %b want 1", drop); end
    shoot(504, 472, 0, 0);
    vectors++; if (slot_of(bus, 1) !== mk(504, 472, 0, 0)) begin errors++; $display("FAIL range_max_ok: got %h want %h", slot_of(bus, 1), mk(504, 472, 0, 0)); end
  endtask

  task automatic test_clear_mid();
    int fd;
    int bad;
    do_clear();
    shoot(100, 100, 1, 0);
    shoot(200, 200, 2, 1);
    shoot(300, 300, 3, 0);
    screenEnd = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      if (k == 4) screenEnd = 1'b0;
      if (k == 5) begin fireX = 9'd11; fireY = 9'd22; fireDir = 2'b00; fireOwner = 1'b1; fire = 1'b1; end
      tick();
      if (k == 5) fire = 1'b0;
    end
    vectors++; if (slot_of(bus, 0) !== mk(104, 100, 1, 0) || slot_of(bus, 2) !== mk(296, 300, 3, 0)) begin
      errors++; $display("FAIL mid_sweep: slot0 %h slot2 %h want %h %h", slot_of(bus, 0), slot_of(bus, 2), mk(104, 100, 1, 0), mk(296, 300, 3, 0));
    end
    clearAll = 1'b1;
    tick();
    clearAll = 1'b0;
    fd = first_diff(bus, '0);
    vectors++; if (fd != -1) begin errors++; $display("FAIL clear_bus: slot %0d got %h want 0", fd, slot_of(bus, fd)); end
`ifdef BULLET_COUNT_EN
    vectors++; if (cnt !== 7'd0) begin errors++; $display("FAIL clear_cnt: got %0d want 0", cnt); end
`endif
    bad = 0;
    repeat (70) begin
      tick();
      if (acc !== 1'b0 || bus !== '0) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL clear_no_pending: got %0d bad cycles want 0", bad); end
    fireX = 9'd5; fireY = 9'd6; fireDir = 2'b00; fireOwner = 1'b0;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
    vectors++; if (acc !== 1'b1 || slot_of(bus, 0) !== mk(5, 6, 0, 0)) begin
      errors++; $display("FAIL clear_idle: acc %b slot0 %h want 1 %h", acc, slot_of(bus, 0), mk(5, 6, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_fire();
    test_move();
    test_retire();
    test_full();
    test_back_to_back();
    test_simultaneous();
    test_clear_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
